// File: rtl/timer_bank.sv
// Bank of independent programmable timers, each periodic or one-shot, with
// per-channel terminal-count pulse, square-wave and busy outputs.
module timer_bank #(
  parameter int WIDTH    = 26,
  parameter int CHANNELS = 4,
  parameter int MODULE   = 50000000,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0] start,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] tc,
  output logic [CHANNELS-1:0] sq,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state_r, state_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] mod_r, mod_s;
    logic             tc_r, tc_s;
    logic             sq_r, sq_s;
    logic             busy_r;
    logic             wr_hit_s;
    logic             wrap_s;

    // An out-of-range wr_ch never equals any channel index, so it is ignored.
    assign wr_hit_s = wr_en && (wr_ch == CW'(g));
    assign wrap_s   = (mod_r != {WIDTH{1'b0}}) && (cnt_r == (mod_r - WIDTH'(1)));

    // Next-state logic; priority is write, retrigger, wrap, increment.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      mod_s   = mod_r;
      tc_s    = 1'b0;
      sq_s    = sq_r;
      if (wr_hit_s) begin
        mod_s = wr_data;
        cnt_s = {WIDTH{1'b0}};
      end else if (en[g]) begin
        case (state_r)
          IDLE: begin
            if (!mode[g]) begin
              state_s = RUN;
            end else if (start[g]) begin
              state_s = RUN;
              cnt_s   = {WIDTH{1'b0}};
            end else begin
              state_s = IDLE;
            end
          end
          RUN: begin
            if (mode[g] && start[g]) begin
              cnt_s = {WIDTH{1'b0}};
            end else if (wrap_s) begin
              cnt_s   = {WIDTH{1'b0}};
              tc_s    = 1'b1;
              sq_s    = ~sq_r;
              state_s = mode[g] ? IDLE : RUN;
            end else if (mod_r != {WIDTH{1'b0}}) begin
              cnt_s = cnt_r + WIDTH'(1);
            end else begin
              cnt_s = cnt_r;
            end
          end
          default: state_s = IDLE;
        endcase
      end else begin
        cnt_s = cnt_r;
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_r <= IDLE;
        cnt_r   <= {WIDTH{1'b0}};
        mod_r   <= WIDTH'(MODULE);
        tc_r    <= 1'b0;
        sq_r    <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        mod_r   <= mod_s;
        tc_r    <= tc_s;
        sq_r    <= sq_s;
        busy_r  <= (state_s == RUN);
      end
    end

    assign tc[g]   = tc_r;
    assign sq[g]   = sq_r;
    assign busy[g] = busy_r;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a per-channel behavioural model.
module tb_timer_bank;

  logic       clk;
  logic       rst;
  logic [3:0] en, mode, start;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_data;
  logic [3:0] tc4, sq4, busy4;
  logic [2:0] tc3, sq3, busy3;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  timer_bank #(.WIDTH(8), .CHANNELS(4), .MODULE(5)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .tc(tc4), .sq(sq4), .busy(busy4)
  );

  // Three-channel copy sees the same traffic; wr_ch=3 must not touch it.
  timer_bank #(.WIDTH(8), .CHANNELS(3), .MODULE(5)) dut3 (
    .clk(clk), .rst(rst), .en(en[2:0]), .mode(mode[2:0]), .start(start[2:0]),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .tc(tc3), .sq(sq3), .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: "elapsed" counts enabled cycles into the current period.
  typedef struct {
    bit run;
    int elapsed;
    int modulus;
    bit tc;
    bit sq;
  } ch_t;

  ch_t m [4];

  function automatic ch_t step(input ch_t c, input int i);
    ch_t n = c;
    n.tc = 1'b0;
    if (wr_en && int'(wr_ch) == i) begin
      n.modulus = int'(wr_data);
      n.elapsed = 0;
    end else if (en[i]) begin
      if (!c.run) begin
        if (!mode[i]) n.run = 1'b1;
        else if (start[i]) begin
          n.run = 1'b1;
          n.elapsed = 0;
        end
      end else if (mode[i] && start[i]) begin
        n.elapsed = 0;
      end else if (c.modulus > 0) begin
        n.elapsed = c.elapsed + 1;
        if (n.elapsed == c.modulus) begin
          n.elapsed = 0;
          n.tc = 1'b1;
          n.sq = ~c.sq;
          if (mode[i]) n.run = 1'b0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        m[i] <= '{run: 1'b0, elapsed: 0, modulus: 5, tc: 1'b0, sq: 1'b0};
    end else begin
      for (int i = 0; i < 4; i++)
        m[i] <= step(m[i], i);
    end
  end

  function automatic logic [11:0] exp4();
    logic [3:0] t, s, b;
    for (int i = 0; i < 4; i++) begin
      t[i] = m[i].tc;
      s[i] = m[i].sq;
      b[i] = m[i].run;
    end
    return {t, s, b};
  endfunction

  function automatic logic [8:0] exp3();
    logic [11:0] v;
    v = exp4();
    return {v[10:8], v[6:4], v[2:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("model_dut4", 32'({tc4, sq4, busy4}), 32'(exp4()));
        chk("model_dut3", 32'({tc3, sq3, busy3}), 32'(exp3()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 4'b0000; mode = 4'b0000; start = 4'b0000;
    wr_en = 1'b0; wr_ch = 2'd0; wr_data = 8'd0;
    #2 rst = 1'b0;
    #1 started = 1'b1;
    chk("reset_out4", 32'({tc4, sq4, busy4}), 32'(12'h000));
    chk("reset_out3", 32'({tc3, sq3, busy3}), 32'(9'h000));
    tick();
    mode = 4'b1010; en = 4'b1111; rst = 1'b1;
    tick();                                                   // edge 1
    chk("busy_after_release", 32'(busy4), 32'(4'b0101));
    repeat (4) tick();                                        // edge 5
    chk("tc_before_wrap", 32'(tc4), 32'(4'b0000));
    tick();                                                   // edge 6
    chk("tc_first_wrap", 32'(tc4), 32'(4'b0101));
    chk("sq_first_toggle", 32'(sq4), 32'(4'b0101));
    start = 4'b1000; tick(); start = 4'b0000;                 // edge 7
    chk("oneshot_busy", 32'(busy4), 32'(4'b1101));
    repeat (4) tick();                                        // edge 11
    chk("tc_second_wrap", 32'(tc4), 32'(4'b0101));
    chk("sq_back_low", 32'(sq4), 32'(4'b0000));
    chk("oneshot_still_busy", 32'(busy4), 32'(4'b1101));
    tick();                                                   // edge 12
    chk("oneshot_tc", 32'(tc4), 32'(4'b1000));
    chk("oneshot_done", 32'(busy4), 32'(4'b0101));
    start = 4'b0010; tick(); start = 4'b0000;                 // edge 13
    repeat (3) tick();                                        // edge 16
    start = 4'b0010; tick(); start = 4'b0000;                 // edge 17
    repeat (4) tick();                                        // edge 21
    chk("retrig_busy", 32'(busy4), 32'(4'b0111));
    chk("retrig_no_tc", 32'(tc4), 32'(4'b0101));
    tick();                                                   // edge 22
    chk("retrig_tc", 32'(tc4), 32'(4'b0010));
    chk("retrig_done", 32'(busy4), 32'(4'b0101));
    wr_en = 1'b1; wr_ch = 2'd2; wr_data = 8'd3;
    tick(); wr_en = 1'b0;                                     // edge 23
    chk("write_no_tc", 32'(tc4), 32'(4'b0000));
    repeat (3) tick();                                        // edge 26
    chk("mod3_tc", 32'(tc4), 32'(4'b0101));
    repeat (3) tick();                                        // edge 29
    chk("mod3_tc_again", 32'(tc4), 32'(4'b0100));
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'd1; mode = 4'b1000;
    tick(); wr_en = 1'b0;                                     // edge 30
    tick();                                                   // edge 31
    repeat (3) begin
      tick();
      chk("mod1_tc_steady", 32'(tc4[1]), 32'(1'b1));
    end

    for (int k = 0; k < 3000; k++) begin
      en    = 4'(~($urandom & $urandom & $urandom));
      start = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) mode = 4'($urandom);
      wr_en   = ($urandom_range(0, 15) == 0);
      wr_ch   = 2'($urandom);
      wr_data = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      if (k == 1500 || $urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1 chk("async_reset", 32'({tc4, sq4, busy4, tc3, sq3, busy3}), 32'(21'h0));
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end
    wr_en = 1'b0; start = 4'b0000;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
